dsram_responder: RTL and testbench

DSRAM_RESPONDER -- requirements
Module: dsram_responder

---
 rtl/dsram_pkg.sv | 22 ++
 rtl/dsram_responder_if.sv | 26 ++
 rtl/dsram_rsp_fifo.sv | 61 ++++++
 rtl/dsram_responder.sv | 84 ++++++++
 tb/tb_dsram_responder.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/dsram_pkg.sv
// dsram_pkg -- shared definitions for the data-SRAM responder.
//   ADDR_W_DEF : default word-index width of the internal RAM
//   RSP_DEPTH  : response FIFO depth (max outstanding requests)
//   CNT_W      : width of the FIFO occupancy counter
//   rsp_t      : response FIFO entry {wr, rdata}
//   size_e     : data_sram_size encodings (informational only)
package dsram_pkg;
   localparam int ADDR_W_DEF = 12;
   localparam int RSP_DEPTH  = 2;
   localparam int CNT_W      = $clog2(RSP_DEPTH + 1);

   typedef struct packed {
      logic        wr;
      logic [31:0] rdata;
   } rsp_t;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_e;
endpackage

// File: rtl/dsram_responder_if.sv
// dsram_responder_if -- data-SRAM request/response bus.
//   master : drives req/wr/size/wstrb/addr/wdata, sees addr_ok/data_ok/rdata
//   slave  : the responder side
interface dsram_responder_if;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
             data_sram_addr, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

   modport slave (
      input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
             data_sram_addr, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );
endinterface

// File: rtl/dsram_rsp_fifo.sv
// dsram_rsp_fifo -- RSP_DEPTH-entry in-order response FIFO.
//   clk, reset : clock, async active-high reset (clears pointers and count)
//   push, push_data : enqueue one entry (caller guarantees !full)
//   pop        : dequeue head (caller guarantees !empty)
//   full, empty, head : status and current head entry
module dsram_rsp_fifo
   import dsram_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  rsp_t push_data,
   input  logic pop,
   output logic full,
   output logic empty,
   output rsp_t head
);
   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

   rsp_t             buf_q [RSP_DEPTH];
   rsp_t             buf_d [RSP_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      buf_d    = buf_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         buf_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // push and pop together leave occupancy unchanged
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // storage needs no reset: only entries behind a valid count are observed
   always_ff @(posedge clk) buf_q <= buf_d;

   assign full  = (cnt_q == CNT_W'(RSP_DEPTH));
   assign empty = (cnt_q == '0);
   assign head  = buf_q[rd_ptr_q];
endmodule

// File: rtl/dsram_responder.sv
// dsram_responder -- data-SRAM slave with 4*2^ADDR_W bytes of RAM and up to
// RSP_DEPTH outstanding requests answered in order.
//   clk   : rising-edge clock
//   reset : async active-high reset (control only; RAM keeps its contents)
//   bus   : dsram_responder_if.slave (req/wr/size/wstrb/addr/wdata in,
//           addr_ok/data_ok/rdata out)
// Params : ADDR_W (word-index width), STALL_CYCLES (extra response delay).
// Macro  : DSRAM_STALL_EN -- when defined, each FIFO head waits STALL_CYCLES
//          extra cycles before data_ok; when undefined latency is 1 cycle.
module dsram_responder
   import dsram_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int STALL_CYCLES = 3
)(
   input  logic              clk,
   input  logic              reset,
   dsram_responder_if.slave  bus
);
   logic [31:0]       mem_q [2**ADDR_W];
   logic [ADDR_W-1:0] idx;
   logic              accept, eligible, pop, full, empty;
   rsp_t              push_data, head;

   // high address bits wrap; low two bits select lanes via wstrb; size is advisory
   assign idx = bus.data_sram_addr[ADDR_W+1:2];
   logic unused_bits;
   assign unused_bits = &{1'b0, bus.data_sram_addr, bus.data_sram_size};

   // addr_ok depends only on occupancy (and reset), never on req
   assign bus.data_sram_addr_ok = !reset && !full;
   assign accept = bus.data_sram_req && bus.data_sram_addr_ok;

   // the RAM read happens at the accept edge, so it sees every earlier write
   always_comb begin
      push_data.wr    = bus.data_sram_wr;
      push_data.rdata = bus.data_sram_wr ? 32'h0 : mem_q[idx];
   end

   always_ff @(posedge clk) begin
      if (accept && bus.data_sram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.data_sram_wstrb[i]) mem_q[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
         end
      end
   end

`ifdef DSRAM_STALL_EN
   localparam int SC_W = $clog2(STALL_CYCLES + 2);
   logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;

   // counts cycles the current head has waited; restarts for every new head
   always_comb begin
      stall_cnt_d = stall_cnt_q + SC_W'(1);
      if (empty || pop) stall_cnt_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign eligible = !empty && (stall_cnt_q == SC_W'(STALL_CYCLES));
`else
   localparam int unused_stall_cycles = STALL_CYCLES;
   assign eligible = !empty;
`endif

   // no backpressure: an eligible head is presented and popped in the same cycle
   assign pop                   = eligible;
   assign bus.data_sram_data_ok = eligible;
   assign bus.data_sram_rdata   = eligible ? head.rdata : 32'h0;

   dsram_rsp_fifo u_rsp_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (accept),
      .push_data (push_data),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .head      (head)
   );
endmodule

// File: tb/tb_dsram_responder.sv
module tb_dsram_responder;
`ifdef DSRAM_STALL_EN
   localparam int S = 3;
`else
   localparam int S = 0;
`endif

   typedef struct {
      logic [31:0] rdata;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   last_rsp = -100;
   exp_t sb[$];

   dsram_responder_if bus ();

   dsram_responder #(.ADDR_W(12), .STALL_CYCLES(S)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: pops expected responses and checks data and arrival cycle
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.data_sram_data_ok) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_data_ok: got rdata=%h with nothing outstanding", bus.data_sram_rdata);
            end else begin
               exp_t e;
               int   exp_c;
               e = sb.pop_front();
               exp_c = (e.acc + S > last_rsp + 1 + S) ? e.acc + S : last_rsp + 1 + S;
               n_cmp++;
               if (bus.data_sram_rdata !== e.rdata) begin
                  n_bad++;
                  $display("FAIL rsp_data: got %h expected %h", bus.data_sram_rdata, e.rdata);
               end
               n_cmp++;
               if (cyc != exp_c) begin
                  n_bad++;
                  $display("FAIL rsp_cycle: got cycle %0d expected %0d", cyc, exp_c);
               end
               last_rsp = cyc;
            end
         end else begin
            n_cmp++;
            if (bus.data_sram_rdata !== 32'h0) begin
               n_bad++;
               $display("FAIL idle_rdata: got %h expected 00000000", bus.data_sram_rdata);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_rdata);
      int guard = 0;
      @(negedge clk);
      bus.data_sram_req   = 1'b1;
      bus.data_sram_wr    = wr;
      bus.data_sram_size  = 2'd2;
      bus.data_sram_wstrb = strb;
      bus.data_sram_addr  = addr;
      bus.data_sram_wdata = wdata;
      while (!bus.data_sram_addr_ok && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.data_sram_addr_ok) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: addr=%h addr_ok stayed 0", addr);
         bus.data_sram_req = 1'b0;
      end else begin
         sb.push_back('{rdata: exp_rdata, acc: cyc + 1});
         @(posedge clk);
         #1 bus.data_sram_req = 1'b0;
      end
   endtask

   task automatic drain();
      int guard = 0;
      while (sb.size() != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: %0d responses missing", sb.size());
      end
   endtask

   initial begin
      bus.data_sram_req   = 1'b0;
      bus.data_sram_wr    = 1'b0;
      bus.data_sram_size  = 2'd2;
      bus.data_sram_wstrb = 4'h0;
      bus.data_sram_addr  = 32'h0;
      bus.data_sram_wdata = 32'h0;

      // reset state
      @(negedge clk);
      check("rst_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h0);
      check("rst_data_ok", {31'h0, bus.data_sram_data_ok}, 32'h0);
      check("rst_rdata", bus.data_sram_rdata, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("post_rst_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h1);

      // full write then read next cycle
      issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
      issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
      // partial write merge
      issue(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0);
      issue(1'b1, 32'h20, 32'h0000AA00, 4'h2, 32'h0);
      issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h1122AA44);
      // address wrap above ADDR_W+1
      issue(1'b0, 32'h4020, 32'h0, 4'h0, 32'h1122AA44);
      // zero-strobe write still responds and changes nothing
      issue(1'b1, 32'h24, 32'hCAFEF00D, 4'hF, 32'h0);
      issue(1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, 32'h0);
      issue(1'b0, 32'h24, 32'h0, 4'h0, 32'hCAFEF00D);
      // single byte lane 0
      issue(1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0);
      issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA);
      // top word and wrapped alias of it
      issue(1'b1, 32'h3FFC, 32'h55AA55AA, 4'hF, 32'h0);
      issue(1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 32'h55AA55AA);
      drain();

      // four back-to-back reads
      issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA);
      issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h1122AA44);
      issue(1'b0, 32'h24, 32'h0, 4'h0, 32'hCAFEF00D);
      issue(1'b0, 32'h3FFC, 32'h0, 4'h0, 32'h55AA55AA);
      drain();

      // reset with responses outstanding: they must be discarded
      issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h0);
      if (S > 0) issue(1'b0, 32'h24, 32'h0, 4'h0, 32'h0);
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      check("mid_rst_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h0);
      check("mid_rst_data_ok", {31'h0, bus.data_sram_data_ok}, 32'h0);
      check("mid_rst_rdata", bus.data_sram_rdata, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("after_rst_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h1);
      // monitor flags any stray data_ok during these idle cycles
      repeat (8) @(negedge clk);
      // RAM survives reset
      issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h1122AA44);
      issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA);
      drain();
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
